// File: rtl/pe_row_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_feeder_pkg
// Brief    : Shared state encoding and buffer-select constants for the
//            PE row feeder.
// Revision : 1.0 - initial release
// ============================================================================
package pe_feeder_pkg;

  localparam int STATE_W = 3;

  // Controller states; the encoding is fixed so it reads the same in waves
  // and in any software that peeks at it.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_EMIT_F   = 3'd1,
    ST_EMIT_I   = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  // wr_sel decode: which row buffer a write targets.
  localparam logic SEL_FILTER = 1'b0;
  localparam logic SEL_IFMAP  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pe_row_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : pe_row_feeder_if
// Brief    : Buffer-write, launch and PE-chain signals for the row feeder.
//            master = buffer/launch driver side, slave = the feeder itself.
// Revision : 1.0 - initial release
// ============================================================================
interface pe_row_feeder_if #(
  parameter int BITWIDTH      = 16,
  parameter int RF_ADDR_WIDTH = 3
);

  // Row-buffer write port and launch
  logic                     wr_en;
  logic                     wr_sel;
  logic [RF_ADDR_WIDTH-1:0] wr_addr;
  logic [BITWIDTH-1:0]      wr_data;
  logic                     start;

  // PE chain side
  logic                     pe_ready;
  logic                     filter_enable;
  logic [BITWIDTH-1:0]      filter;
  logic                     ifmap_enable;
  logic [BITWIDTH-1:0]      ifmap;

  // Status
  logic                     busy;
  logic                     done;
  logic                     wr_err;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, pe_ready,
    input  filter_enable, filter, ifmap_enable, ifmap, busy, done, wr_err
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, pe_ready,
    output filter_enable, filter, ifmap_enable, ifmap, busy, done, wr_err
  );

endinterface
`default_nettype wire

// File: rtl/pe_row_feeder_row_buf.sv
`default_nettype none
// ============================================================================
// Module   : feeder_row_buf
// Brief    : KERNEL_SIZE x BITWIDTH row register array with synchronous
//            clear, gated write and combinational read.
// Revision : 1.0 - initial release
// ============================================================================
module feeder_row_buf #(
  parameter int BITWIDTH      = 16,
  parameter int KERNEL_SIZE   = 3,
  parameter int RF_ADDR_WIDTH = 3
) (
  input  wire logic                     clk,
  input  wire logic                     rstb,
  input  wire logic                     wr_en_i,
  input  wire logic [RF_ADDR_WIDTH-1:0] wr_addr_i,
  input  wire logic [BITWIDTH-1:0]      wr_data_i,
  input  wire logic [RF_ADDR_WIDTH-1:0] rd_addr_i,
  output logic      [BITWIDTH-1:0]      rd_data_o
);

  // Packed so each entry is a plain slice of one vector.
  logic [KERNEL_SIZE-1:0][BITWIDTH-1:0] mem_q;

  // Storage: cleared on reset, one entry updated per accepted write.
  // Addresses at or beyond KERNEL_SIZE match no entry and change nothing.
  always_ff @(posedge clk) begin
    if (rstb) begin
      mem_q <= '0;
    end else if (wr_en_i) begin
      for (int i = 0; i < KERNEL_SIZE; i++) begin
        if (wr_addr_i == RF_ADDR_WIDTH'(i)) begin
          mem_q[i] <= wr_data_i;
        end
      end
    end
  end

  // Read mux; an out-of-range address reads as zero.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      if (rd_addr_i == RF_ADDR_WIDTH'(i)) begin
        rd_data_o = mem_q[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pe_row_feeder.sv
`default_nettype none
// ============================================================================
// Module   : pe_row_feeder
// Brief    : Holds one filter row and one ifmap row and streams them into a
//            PE chain interleaved F0,I0,F1,I1,... then waits for the chain's
//            ready and pulses done. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module pe_row_feeder
  import pe_feeder_pkg::*;
#(
  parameter int BITWIDTH      = 16,
  parameter int KERNEL_SIZE   = 3,
  parameter int RF_ADDR_WIDTH = 3
) (
  input  wire logic       clk,
  input  wire logic       rstb,
  pe_row_feeder_if.slave  bus
);

  localparam logic [RF_ADDR_WIDTH-1:0] c_LAST_IDX = RF_ADDR_WIDTH'(KERNEL_SIZE - 1);
  // One extra bit so KERNEL_SIZE == 2**RF_ADDR_WIDTH is representable.
  localparam logic [RF_ADDR_WIDTH:0]   c_KSIZE    = (RF_ADDR_WIDTH + 1)'(KERNEL_SIZE);

  state_e                   state_q, state_d;
  logic [RF_ADDR_WIDTH-1:0] idx_q, idx_d;

  logic                     fen_q, fen_d;
  logic [BITWIDTH-1:0]      filt_q, filt_d;
  logic                     ien_q, ien_d;
  logic [BITWIDTH-1:0]      ifm_q, ifm_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic                     w_wr_ok;
  logic                     w_fbuf_we;
  logic                     w_ibuf_we;
  logic [BITWIDTH-1:0]      w_frd;
  logic [BITWIDTH-1:0]      w_ird;

  // Buffers only change while idle, so a running stream always sees a
  // stable snapshot; a write alongside start still lands before the first read.
  assign w_wr_ok   = bus.wr_en && (state_q == ST_IDLE) &&
                     ({1'b0, bus.wr_addr} < c_KSIZE);
  assign w_fbuf_we = w_wr_ok && (bus.wr_sel == SEL_FILTER);
  assign w_ibuf_we = w_wr_ok && (bus.wr_sel == SEL_IFMAP);

  feeder_row_buf #(
    .BITWIDTH      (BITWIDTH),
    .KERNEL_SIZE   (KERNEL_SIZE),
    .RF_ADDR_WIDTH (RF_ADDR_WIDTH)
  ) u_fbuf (
    .clk       (clk),
    .rstb      (rstb),
    .wr_en_i   (w_fbuf_we),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .rd_addr_i (idx_q),
    .rd_data_o (w_frd)
  );

  feeder_row_buf #(
    .BITWIDTH      (BITWIDTH),
    .KERNEL_SIZE   (KERNEL_SIZE),
    .RF_ADDR_WIDTH (RF_ADDR_WIDTH)
  ) u_ibuf (
    .clk       (clk),
    .rstb      (rstb),
    .wr_en_i   (w_ibuf_we),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .rd_addr_i (idx_q),
    .rd_data_o (w_ird)
  );

  // Next-state and next-output decode; outputs follow the current state by
  // one cycle, so every enable appears the cycle after its state is entered.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fen_d   = 1'b0;
    filt_d  = '0;
    ien_d   = 1'b0;
    ifm_d   = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = bus.wr_en && !w_wr_ok;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_EMIT_F;
          idx_d   = '0;
        end
      end
      ST_EMIT_F: begin
        fen_d   = 1'b1;
        filt_d  = w_frd;
        busy_d  = 1'b1;
        state_d = ST_EMIT_I;
      end
      ST_EMIT_I: begin
        ien_d  = 1'b1;
        ifm_d  = w_ird;
        busy_d = 1'b1;
        if (idx_q == c_LAST_IDX) begin
          state_d = ST_WAIT_RDY;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_EMIT_F;
        end
      end
      ST_WAIT_RDY: begin
        busy_d = 1'b1;
        if (bus.pe_ready) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, index and output registers; reset aborts any stream at once.
  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      fen_q   <= 1'b0;
      filt_q  <= '0;
      ien_q   <= 1'b0;
      ifm_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fen_q   <= fen_d;
      filt_q  <= filt_d;
      ien_q   <= ien_d;
      ifm_q   <= ifm_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.filter_enable = fen_q;
  assign bus.filter        = filt_q;
  assign bus.ifmap_enable  = ien_q;
  assign bus.ifmap         = ifm_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.wr_err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_row_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_row_feeder
// Brief    : Directed self-checking bench for pe_row_feeder (K=3, 16-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_row_feeder;

  localparam int BW = 16;
  localparam int KS = 3;
  localparam int AW = 3;

  logic clk;
  logic rstb;
  int   total = 0;
  int   bad   = 0;

  pe_row_feeder_if #(.BITWIDTH(BW), .RF_ADDR_WIDTH(AW)) bus_if ();

  pe_row_feeder #(
    .BITWIDTH      (BW),
    .KERNEL_SIZE   (KS),
    .RF_ADDR_WIDTH (AW)
  ) u_dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic fe, input logic [BW-1:0] f,
                            input logic ie, input logic [BW-1:0] iv,
                            input logic b, input logic d, input logic e);
    logic [2*BW+4:0] obs;
    logic [2*BW+4:0] exp;
    obs = {bus_if.filter_enable, bus_if.filter, bus_if.ifmap_enable, bus_if.ifmap,
           bus_if.busy, bus_if.done, bus_if.wr_err};
    exp = {fe, f, ie, iv, b, d, e};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed={fe,f,ie,i,busy,done,err}=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_idle(input string tag);
    expect_out(tag, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_wait(input string tag);
    expect_out(tag, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic expect_done(input string tag);
    expect_out(tag, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  // Idle-time write; checks the wr_err result one edge later.
  task automatic wr(input string tag, input logic sel, input logic [AW-1:0] a,
                    input logic [BW-1:0] d, input logic exp_err);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_sel  = sel;
    bus_if.wr_addr = a;
    bus_if.wr_data = d;
    step();
    bus_if.wr_en   = 1'b0;
    expect_out(tag, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, exp_err);
  endtask

  // Pulse start; outputs right after the sampling edge still reflect IDLE.
  task automatic launch(input string tag);
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    expect_idle(tag);
  endtask

  task automatic run_stream(input string tag,
                            input logic [BW-1:0] f0, input logic [BW-1:0] i0,
                            input logic [BW-1:0] f1, input logic [BW-1:0] i1,
                            input logic [BW-1:0] f2, input logic [BW-1:0] i2);
    step(); expect_out({tag, "_F0"}, 1'b1, f0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(); expect_out({tag, "_I0"}, 1'b0, '0, 1'b1, i0, 1'b1, 1'b0, 1'b0);
    step(); expect_out({tag, "_F1"}, 1'b1, f1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(); expect_out({tag, "_I1"}, 1'b0, '0, 1'b1, i1, 1'b1, 1'b0, 1'b0);
    step(); expect_out({tag, "_F2"}, 1'b1, f2, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(); expect_out({tag, "_I2"}, 1'b0, '0, 1'b1, i2, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rstb           = 1'b1;
    bus_if.wr_en   = 1'b0;
    bus_if.wr_sel  = 1'b0;
    bus_if.wr_addr = '0;
    bus_if.wr_data = '0;
    bus_if.start   = 1'b0;
    bus_if.pe_ready = 1'b0;

    // Reset state
    step();
    step();
    expect_idle("reset");
    rstb = 1'b0;

    // Load rows 1,2,3 / 1,2,3
    wr("wr_f0", 1'b0, 3'd0, 16'd1, 1'b0);
    wr("wr_f1", 1'b0, 3'd1, 16'd2, 1'b0);
    wr("wr_f2", 1'b0, 3'd2, 16'd3, 1'b0);
    wr("wr_i0", 1'b1, 3'd0, 16'd1, 1'b0);
    wr("wr_i1", 1'b1, 3'd1, 16'd2, 1'b0);
    wr("wr_i2", 1'b1, 3'd2, 16'd3, 1'b0);

    // Basic stream, ready raised right after the stream
    launch("basic_start");
    run_stream("basic", 16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3);
    bus_if.pe_ready = 1'b1;
    step(); expect_wait("basic_wait");
    step(); expect_done("basic_done");
    step(); expect_idle("basic_after");
    bus_if.pe_ready = 1'b0;

    // Backpressure: 10 cycles of no ready
    launch("bp_start");
    run_stream("bp", 16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3);
    for (int n = 0; n < 10; n++) begin
      step(); expect_wait("bp_hold");
    end
    bus_if.pe_ready = 1'b1;
    step(); expect_wait("bp_sample");
    step(); expect_done("bp_done");
    step(); expect_idle("bp_after");
    bus_if.pe_ready = 1'b0;

    // Ignored inputs: write while busy, start mid-stream
    launch("ign_start");
    step(); expect_out("ign_F0", 1'b1, 16'd1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_sel  = 1'b0;
    bus_if.wr_addr = 3'd0;
    bus_if.wr_data = 16'd7;
    step(); expect_out("ign_I0_err", 1'b0, '0, 1'b1, 16'd1, 1'b1, 1'b0, 1'b1);
    bus_if.wr_en   = 1'b0;
    step(); expect_out("ign_F1", 1'b1, 16'd2, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    bus_if.start = 1'b1;
    step(); expect_out("ign_I1", 1'b0, '0, 1'b1, 16'd2, 1'b1, 1'b0, 1'b0);
    bus_if.start = 1'b0;
    step(); expect_out("ign_F2", 1'b1, 16'd3, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(); expect_out("ign_I2", 1'b0, '0, 1'b1, 16'd3, 1'b1, 1'b0, 1'b0);
    step(); expect_wait("ign_wait0");
    step(); expect_wait("ign_wait1");
    bus_if.pe_ready = 1'b1;
    step(); expect_wait("ign_sample");
    step(); expect_done("ign_done");
    step(); expect_idle("ign_after");
    wr("wr_addr5", 1'b0, 3'd5, 16'd9, 1'b1);

    // Replay without new writes (pe_ready held high)
    launch("replay_start");
    run_stream("replay", 16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3);
    step(); expect_wait("replay_wait");
    step(); expect_done("replay_done");
    step(); expect_idle("replay_after");

    // Write ifmap[0] = -4 together with start
    bus_if.wr_en   = 1'b1;
    bus_if.wr_sel  = 1'b1;
    bus_if.wr_addr = 3'd0;
    bus_if.wr_data = 16'hFFFC;
    bus_if.start   = 1'b1;
    step();
    bus_if.wr_en   = 1'b0;
    bus_if.start   = 1'b0;
    expect_idle("same_start");
    run_stream("same", 16'd1, 16'hFFFC, 16'd2, 16'd2, 16'd3, 16'd3);
    step(); expect_wait("same_wait");
    step(); expect_done("same_done");
    step(); expect_idle("same_after");

    // Reset during the second filter emit
    launch("rst_start");
    step(); expect_out("rst_F0", 1'b1, 16'd1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(); expect_out("rst_I0", 1'b0, '0, 1'b1, 16'hFFFC, 1'b1, 1'b0, 1'b0);
    step(); expect_out("rst_F1", 1'b1, 16'd2, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    rstb = 1'b1;
    step(); expect_idle("rst_abort");
    rstb = 1'b0;
    step(); expect_idle("rst_no_done0");
    step(); expect_idle("rst_no_done1");
    launch("rst_restart");
    run_stream("zero", '0, '0, '0, '0, '0, '0);
    step(); expect_wait("zero_wait");
    step(); expect_done("zero_done");
    step(); expect_idle("zero_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe_row_feeder.md
Name: pe_row_feeder

Overview:
- Upstream feeder for a vertical chain of `pe` instances.
- Holds one filter row and one ifmap row of KERNEL_SIZE signed values each.
- On `start`, streams the two rows into the PE chain as one value per cycle, interleaved filter/ifmap: F0, I0, F1, I1, ... This is the load order the PE register-file FIFOs expect.
- Then waits for the PE chain's `ready` and reports `done`. It replaces hand-sequenced enables with a reusable controller between the global buffer and the PE array.

Parameters:
- BITWIDTH, 16, width of filter/ifmap words (signed).
- KERNEL_SIZE, 3, values per filter row and ifmap row; legal range 1..2**RF_ADDR_WIDTH.
- RF_ADDR_WIDTH, 3, width of `wr_addr`; must match the PE register-file address width.

Ports:
- clk  in  1  rising-edge clock.
- rstb  in  1  synchronous, active-high reset. The name is kept for codebase consistency; the polarity is high.
- wr_en  in  1  write strobe into the row buffers.
- wr_sel  in  1  0 = filter buffer, 1 = ifmap buffer.
- wr_addr  in  RF_ADDR_WIDTH  buffer index.
- wr_data  in  BITWIDTH  signed write data.
- start  in  1  one-cycle launch request.
- pe_ready  in  1  `ready` from the PE chain.
- filter_enable  out  1  to PE `filter_enable`.
- filter  out  BITWIDTH  to PE `filter`.
- ifmap_enable  out  1  to PE `ifmap_enable`.
- ifmap  out  BITWIDTH  to PE `ifmap`.
- busy  out  1  high from the first emit cycle until `done`.
- done  out  1  one-cycle pulse when the PE chain reports ready.
- wr_err  out  1  one-cycle pulse on an ignored write.

Behaviour:
- Reset:
  - All outputs 0; FSM to IDLE; index counter to 0.
  - Buffer contents are cleared to 0.
  - Reset asserted mid-stream aborts immediately. No further enables are issued, and `done` is not pulsed.
- Outputs are registered. `filter`/`ifmap` are driven 0 whenever their enable is 0.
- Buffer write, at the rising edge when `wr_en`=1:
  - The write commits only if the FSM is IDLE and `wr_addr` < KERNEL_SIZE.
  - Otherwise it is dropped and `wr_err` pulses on the following cycle.
- FSM states: IDLE, EMIT_F, EMIT_I, WAIT_RDY, DONE.
- IDLE:
  - `start`=1 sampled at edge T moves to EMIT_F with idx=0.
  - A write in the same cycle as `start` commits at edge T and is used by the stream.
- EMIT_F:
  - `filter_enable`=1, `filter`=fbuf[idx], `busy`=1 in the cycle after entry.
  - Next state EMIT_I.
- EMIT_I:
  - `ifmap_enable`=1, `ifmap`=ibuf[idx].
  - If idx = KERNEL_SIZE-1, go to WAIT_RDY. Otherwise idx+1 and go to EMIT_F.
- Never: both enables high in the same cycle, or either enable held for 2 consecutive cycles.
- Timing:
  - Stream length is exactly 2*KERNEL_SIZE cycles.
  - The first enable is visible 1 cycle after the `start` edge.
- WAIT_RDY:
  - All enables 0.
  - Stay until `pe_ready`=1 is sampled, then go to DONE.
  - No timeout; `pe_ready` high already on entry exits after 1 cycle.
- DONE:
  - `done`=1 and `busy`=0 for exactly one cycle; return to IDLE.
  - Buffers are retained, so a later `start` replays the same rows.
- `start` in any state other than IDLE is ignored, with no queueing.
- Values are passed through unmodified; there is no arithmetic, sign change or truncation.
- KERNEL_SIZE=1 degenerates to F0, I0 and then WAIT_RDY.

Decomposition:
- Package `pe_feeder_pkg`:
  - State enum/localparams: IDLE=0, EMIT_F=1, EMIT_I=2, WAIT_RDY=3, DONE=4; 3-bit state width.
  - Select constants `SEL_FILTER`=0 and `SEL_IFMAP`=1.
- One natural sub-module, `feeder_row_buf`:
  - A KERNEL_SIZE x BITWIDTH register array with synchronous reset, gated write and combinational read.
  - Instantiated twice, for filter and ifmap.
- FSM, index counter and output registers stay in `pe_row_feeder`.

Test Plan:
- Basic stream:
  - Stimulus: write filter 1,2,3 and ifmap 1,2,3 (K=3); pulse `start`; tie `pe_ready`=1 after 6 cycles.
  - Response: enables alternate over 6 cycles carrying F=1, I=1, F=2, I=2, F=3, I=3; `done` pulses once; `busy` is high for the stream plus wait.
- Backpressure on ready:
  - Stimulus: same load; hold `pe_ready`=0 for 10 cycles after the stream, then 1.
  - Response: no enables during the wait; `done` occurs exactly 1 cycle after `pe_ready` is sampled high.
- Ignored inputs:
  - Stimulus: write filter[0]=7 while busy; write addr 5 while idle; pulse `start` mid-stream.
  - Response: `wr_err` pulses twice; a replay still emits F0=1; the stream is not restarted or extended.
- Same-cycle write and start:
  - Stimulus: wr ifmap[0]=-4 together with `start`.
  - Response: the first ifmap emitted is -4 (0xFFFC at BITWIDTH=16).
- Reset mid-stream:
  - Stimulus: assert `rstb` high during the 2nd filter emit.
  - Response: next cycle all outputs are 0, no `done`, buffers read 0; a subsequent `start` emits zeros.
- Replay:
  - Stimulus: after `done`, pulse `start` again without writes.
  - Response: identical 6-cycle sequence 1,1,2,2,3,3.
